// File: rtl/mdio_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mdio_pkg : shared constants and state encoding for mdio_responder      |
// | Revision : 1.0                                                         |
// +-----------------------------------------------------------------------+
package mdio_pkg;

  localparam int DATA_W  = 16;
  localparam int FIELD_W = 5;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] TA_WRITE = 2'b10;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ST      = 4'd1,
    OP      = 4'd2,
    PHYAD   = 4'd3,
    REGAD   = 4'd4,
    TA      = 4'd5,
    WR_DATA = 4'd6,
    RD_DATA = 4'd7,
    SKIP    = 4'd8
  } state_t;

endpackage
`default_nettype wire

// File: rtl/signal_sync.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | signal_sync : multi-flop synchronizer for a single asynchronous bit    |
// | Revision    : 1.0                                                      |
// +-----------------------------------------------------------------------+
module signal_sync #(
  parameter int   Depth    = 2,
  parameter logic ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [Depth-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[Depth-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {Depth{ResetVal}};
    else        sync_q <= sync_d;
  end

  assign q = sync_q[Depth-1];

endmodule
`default_nettype wire

// File: rtl/mdio_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mdio_responder : Clause-22 MDIO target with a register-bank port       |
// | Option : MDIO_PREAMBLE_SUPPRESS_EN accepts ST after a single 1 bit     |
// | Revision : 1.0                                                         |
// +-----------------------------------------------------------------------+
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR     = 5'd1,
  parameter int         PREAMBLE_LEN = 32,
  parameter int         SYNC_DEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mdc,
  input  logic              mdio_in,
  output logic              mdio_out,
  output logic              mdio_oen,
  output logic [4:0]        reg_addr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              reg_we,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              busy
);

  localparam logic [5:0] PRE_MAX = 6'(PREAMBLE_LEN);

  logic mdc_s, mdio_s, rise;
  logic mdc_prev_q, mdc_prev_d;

  signal_sync #(.Depth(SYNC_DEPTH), .ResetVal(1'b0)) u_sync_mdc (
    .clk(clk), .rst_n(rst_n), .d(mdc), .q(mdc_s)
  );
  signal_sync #(.Depth(SYNC_DEPTH), .ResetVal(1'b1)) u_sync_mdio (
    .clk(clk), .rst_n(rst_n), .d(mdio_in), .q(mdio_s)
  );

  state_t              state_q, state_d;
  logic [5:0]          pre_q, pre_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic                is_read_q, is_read_d;
  logic                rd_pend_q, rd_pend_d;
  logic [FIELD_W-1:0]  reg_addr_q, reg_addr_d;
  logic                reg_rd_q, reg_rd_d;
  logic                reg_we_q, reg_we_d;
  logic [DATA_W-1:0]   reg_wdata_q, reg_wdata_d;
  logic                mdio_oen_q, mdio_oen_d;
  logic                mdio_out_q, mdio_out_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0] shift_in;
  logic [11:0]       hdr;
  logic              pre_ok, addr_hit, op_ok, ta_exp;

  assign mdc_prev_d = mdc_s;
  assign rise       = mdc_s & ~mdc_prev_q;
  assign shift_in   = {sh_q[DATA_W-2:0], mdio_s};
  // {op, phyad, regad} as it stands once the last REGAD bit is shifted in
  assign hdr        = {sh_q[10:0], mdio_s};
  assign addr_hit   = (hdr[9:5] == PHY_ADDR);
  assign op_ok      = (hdr[11:10] == OP_READ) || (hdr[11:10] == OP_WRITE);
  assign ta_exp     = cnt_q[0] ? TA_WRITE[0] : TA_WRITE[1];

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  assign pre_ok = (pre_q != 6'd0);
`else
  assign pre_ok = (pre_q == PRE_MAX);
`endif

  always_comb begin
    state_d     = state_q;
    pre_d       = pre_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    is_read_d   = is_read_q;
    rd_pend_d   = reg_rd_q;
    reg_addr_d  = reg_addr_q;
    reg_rd_d    = 1'b0;
    reg_we_d    = 1'b0;
    reg_wdata_d = reg_wdata_q;
    mdio_oen_d  = mdio_oen_q;
    mdio_out_d  = mdio_out_q;
    busy_d      = busy_q;

    // Bank data is taken one clock after the read strobe has been seen
    if (rd_pend_q) sh_d = reg_rdata;

    if (rise) begin
      case (state_q)
        IDLE: begin
          if (mdio_s) begin
            if (pre_q != PRE_MAX) pre_d = pre_q + 6'd1;
          end else begin
            pre_d = 6'd0;
            if (pre_ok) begin
              state_d = ST;
              busy_d  = 1'b1;
            end
          end
        end
        ST: begin
          cnt_d = 5'd0;
          if (mdio_s) begin
            state_d = OP;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
        OP: begin
          sh_d  = shift_in;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd1) begin
            state_d = PHYAD;
            cnt_d   = 5'd0;
          end
        end
        PHYAD: begin
          sh_d  = shift_in;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd4) begin
            state_d = REGAD;
            cnt_d   = 5'd0;
          end
        end
        REGAD: begin
          sh_d  = shift_in;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd4) begin
            cnt_d = 5'd0;
            if (addr_hit && op_ok) begin
              state_d    = TA;
              is_read_d  = (hdr[11:10] == OP_READ);
              reg_addr_d = hdr[4:0];
              reg_rd_d   = (hdr[11:10] == OP_READ);
            end else begin
              state_d = SKIP;
            end
          end
        end
        TA: begin
          if (is_read_q) begin
            mdio_oen_d = 1'b0;
            mdio_out_d = 1'b0;
            state_d    = RD_DATA;
            cnt_d      = 5'd0;
          end else if (mdio_s != ta_exp) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else if (cnt_q == 5'd1) begin
            state_d = WR_DATA;
            cnt_d   = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        WR_DATA: begin
          sh_d  = shift_in;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            reg_we_d    = 1'b1;
            reg_wdata_d = shift_in;
            state_d     = IDLE;
            busy_d      = 1'b0;
          end
        end
        RD_DATA: begin
          if (cnt_q == 5'd16) begin
            mdio_oen_d = 1'b1;
            mdio_out_d = 1'b1;
            state_d    = IDLE;
            busy_d     = 1'b0;
          end else begin
            mdio_out_d = sh_q[DATA_W-1];
            sh_d       = {sh_q[DATA_W-2:0], 1'b0};
            cnt_d      = cnt_q + 5'd1;
          end
        end
        SKIP: begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd17) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_prev_q  <= 1'b0;
      state_q     <= IDLE;
      pre_q       <= 6'd0;
      cnt_q       <= 5'd0;
      sh_q        <= '0;
      is_read_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
      reg_addr_q  <= '0;
      reg_rd_q    <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_wdata_q <= '0;
      mdio_oen_q  <= 1'b1;
      mdio_out_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      mdc_prev_q  <= mdc_prev_d;
      state_q     <= state_d;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      is_read_q   <= is_read_d;
      rd_pend_q   <= rd_pend_d;
      reg_addr_q  <= reg_addr_d;
      reg_rd_q    <= reg_rd_d;
      reg_we_q    <= reg_we_d;
      reg_wdata_q <= reg_wdata_d;
      mdio_oen_q  <= mdio_oen_d;
      mdio_out_q  <= mdio_out_d;
      busy_q      <= busy_d;
    end
  end

  assign mdio_out  = mdio_out_q;
  assign mdio_oen  = mdio_oen_q;
  assign reg_addr  = reg_addr_q;
  assign reg_rd    = reg_rd_q;
  assign reg_we    = reg_we_q;
  assign reg_wdata = reg_wdata_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire
